controle_posicionamento: RTL and testbench

CONTROLE_POSICIONAMENTO -- requirements
Module: controle_posicionamento

---
 rtl/batalha_pkg.sv | 24 ++
 rtl/tabela_frota.sv | 20 ++
 rtl/controle_posicionamento.sv | 152 +++++++++++++++
 tb/tb_controle_posicionamento.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/batalha_pkg.sv
// Shared definitions for the fleet placement logic: ship types, fleet size,
// placement FSM states and the validator response timeout.
package batalha_pkg;

    localparam logic [2:0] PORTA_AVIOES = 3'd0;
    localparam logic [2:0] ENCOURACADO  = 3'd1;
    localparam logic [2:0] HIDROAVIAO   = 3'd2;
    localparam logic [2:0] CRUZADOR     = 3'd3;
    localparam logic [2:0] SUBMARINO    = 3'd4;

    localparam int NUM_PECAS   = 11;
    localparam int TIMEOUT_MAX = 1023;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ESPERA  = 3'd1,
        EMITE   = 3'd2,
        AGUARDA = 3'd3,
        ERRO    = 3'd4,
        PROXIMO = 3'd5,
        FIM     = 3'd6
    } estado_t;

endpackage

// File: rtl/tabela_frota.sv
// Fleet table: maps a fleet slot index to the ship type placed in that slot.
module tabela_frota
    import batalha_pkg::*;
(
    input  logic [3:0] indice,
    output logic [2:0] tipo
);

    always_comb begin
        tipo = SUBMARINO;
        case (indice)
            4'd0:             tipo = PORTA_AVIOES;
            4'd1, 4'd2:       tipo = ENCOURACADO;
            4'd3, 4'd4:       tipo = HIDROAVIAO;
            4'd5, 4'd6, 4'd7: tipo = CRUZADOR;
            default:          tipo = SUBMARINO;
        endcase
    end

endmodule

// File: rtl/controle_posicionamento.sv
// Fleet placement controller for two players. Optional validator response
// timeout is enabled by defining CONTROLE_TIMEOUT_EN.
module controle_posicionamento
    import batalha_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       confirma,
    input  logic [3:0] x_in,
    input  logic [3:0] y_in,
    input  logic       direcao_in,
    input  logic [2:0] orientacao_in,
    input  logic       val_ready,
    input  logic       val_conflito,
    output logic       val_enable,
    output logic [2:0] val_tipo,
    output logic       val_direcao,
    output logic [2:0] val_orientacao,
    output logic [3:0] val_x,
    output logic [3:0] val_y,
    output logic       jogador,
    output logic [3:0] indice,
    output logic       erro,
    output logic       concluido
);

    localparam logic [3:0] ULTIMO_INDICE = 4'(NUM_PECAS - 1);

    estado_t    estado_q, estado_d;
    logic       jogador_q, jogador_d;
    logic [3:0] indice_q, indice_d;
    logic [3:0] x_q, x_d, y_q, y_d;
    logic       dir_q, dir_d;
    logic [2:0] ori_q, ori_d;

`ifdef CONTROLE_TIMEOUT_EN
    localparam logic [9:0] CNT_LIMITE = 10'(TIMEOUT_MAX - 1);
    logic [9:0] cnt_q, cnt_d;
`endif

    // Validator handshake: val_enable is a single-cycle request carrying the
    // latched fields; the validator answers later with a single-cycle val_ready
    // (accepted) or val_conflito (rejected). Responses count only in AGUARDA,
    // and conflito takes priority when both arrive together.
    always_comb begin
        estado_d  = estado_q;
        jogador_d = jogador_q;
        indice_d  = indice_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        ori_d     = ori_q;
`ifdef CONTROLE_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (estado_q)
            IDLE, FIM: begin
                if (start) begin
                    jogador_d = 1'b0;
                    indice_d  = 4'd0;
                    estado_d  = ESPERA;
                end
            end
            ESPERA, ERRO: begin
                if (confirma) begin
                    x_d      = x_in;
                    y_d      = y_in;
                    dir_d    = direcao_in;
                    ori_d    = orientacao_in;
                    estado_d = EMITE;
                end
            end
            EMITE: begin
                estado_d = AGUARDA;
`ifdef CONTROLE_TIMEOUT_EN
                cnt_d    = 10'd0;
`endif
            end
            AGUARDA: begin
                if (val_conflito) begin
                    estado_d = ERRO;
                end else if (val_ready) begin
                    estado_d = PROXIMO;
                end
`ifdef CONTROLE_TIMEOUT_EN
                else if (cnt_q == CNT_LIMITE) begin
                    estado_d = ERRO;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
`endif
            end
            PROXIMO: begin
                if (indice_q < ULTIMO_INDICE) begin
                    indice_d = indice_q + 4'd1;
                    estado_d = ESPERA;
                end else if (!jogador_q) begin
                    jogador_d = 1'b1;
                    indice_d  = 4'd0;
                    estado_d  = ESPERA;
                end else begin
                    estado_d = FIM;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= IDLE;
            jogador_q <= 1'b0;
            indice_q  <= 4'd0;
            x_q       <= 4'd0;
            y_q       <= 4'd0;
            dir_q     <= 1'b0;
            ori_q     <= 3'd0;
`ifdef CONTROLE_TIMEOUT_EN
            cnt_q     <= 10'd0;
`endif
        end else begin
            estado_q  <= estado_d;
            jogador_q <= jogador_d;
            indice_q  <= indice_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
            ori_q     <= ori_d;
`ifdef CONTROLE_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    tabela_frota u_tabela_frota (
        .indice (indice_q),
        .tipo   (val_tipo)
    );

    // Status outputs are pure decodes of the registered state.
    assign val_enable     = (estado_q == EMITE);
    assign erro           = (estado_q == ERRO);
    assign concluido      = (estado_q == FIM);
    assign jogador        = jogador_q;
    assign indice         = indice_q;
    assign val_x          = x_q;
    assign val_y          = y_q;
    assign val_direcao    = dir_q;
    assign val_orientacao = ori_q;

endmodule

// File: tb/tb_controle_posicionamento.sv
// Directed testbench for controle_posicionamento (honours CONTROLE_TIMEOUT_EN).
module tb_controle_posicionamento;
    import batalha_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       confirma = 1'b0;
    logic [3:0] x_in = 4'd0;
    logic [3:0] y_in = 4'd0;
    logic       direcao_in = 1'b0;
    logic [2:0] orientacao_in = 3'd0;
    logic       val_ready = 1'b0;
    logic       val_conflito = 1'b0;
    logic       val_enable;
    logic [2:0] val_tipo;
    logic       val_direcao;
    logic [2:0] val_orientacao;
    logic [3:0] val_x;
    logic [3:0] val_y;
    logic       jogador;
    logic [3:0] indice;
    logic       erro;
    logic       concluido;

    int n_tests = 0;
    int n_fail  = 0;

    // Fleet table written out by hand, one entry per slot.
    logic [2:0] exp_tipo [11] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3,
                                  3'd3, 3'd3, 3'd4, 3'd4, 3'd4};

    controle_posicionamento dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .confirma       (confirma),
        .x_in           (x_in),
        .y_in           (y_in),
        .direcao_in     (direcao_in),
        .orientacao_in  (orientacao_in),
        .val_ready      (val_ready),
        .val_conflito   (val_conflito),
        .val_enable     (val_enable),
        .val_tipo       (val_tipo),
        .val_direcao    (val_direcao),
        .val_orientacao (val_orientacao),
        .val_x          (val_x),
        .val_y          (val_y),
        .jogador        (jogador),
        .indice         (indice),
        .erro           (erro),
        .concluido      (concluido)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_confirma(input logic [3:0] x, input logic [3:0] y,
                                  input logic d, input logic [2:0] o);
        x_in = x; y_in = y; direcao_in = d; orientacao_in = o;
        confirma = 1'b1;
        tick();
        confirma = 1'b0;
    endtask

    task automatic respond(input logic rdy, input logic conf);
        val_ready = rdy;
        val_conflito = conf;
        tick();
        val_ready = 1'b0;
        val_conflito = 1'b0;
    endtask

    task automatic place_ok(input logic [3:0] x, input logic [3:0] y);
        pulse_confirma(x, y, 1'b0, 3'd0);
        tick();
        respond(1'b1, 1'b0);
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({val_enable, val_tipo, val_direcao, val_orientacao, val_x, val_y,
             jogador, indice, erro, concluido} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {val_enable, val_tipo, val_direcao, val_orientacao, val_x,
                      val_y, jogador, indice, erro, concluido});
        end
        n_tests++;
        if (dut.estado_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", dut.estado_q, IDLE);
        end
        pulse_confirma(4'd7, 4'd7, 1'b1, 3'd1);
        respond(1'b1, 1'b1);
        n_tests++;
        if (dut.estado_q !== IDLE || val_enable !== 1'b0 || val_x !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_ignores: state %0d val_enable %0b val_x %0d expected IDLE,0,0",
                     dut.estado_q, val_enable, val_x);
        end
    endtask

    task automatic test_basic();
        pulse_start();
        n_tests++;
        if (dut.estado_q !== ESPERA || jogador !== 1'b0 || indice !== 4'd0) begin
            n_fail++;
            $display("FAIL start: state %0d jog %0b idx %0d expected ESPERA,0,0",
                     dut.estado_q, jogador, indice);
        end
        respond(1'b1, 1'b1);
        n_tests++;
        if (dut.estado_q !== ESPERA || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL espera_ignores_resp: state %0d erro %0b expected ESPERA,0",
                     dut.estado_q, erro);
        end
        pulse_confirma(4'd2, 4'd3, 1'b0, 3'd0);
        n_tests++;
        if (val_enable !== 1'b1 || val_tipo !== 3'd0 || val_x !== 4'd2 ||
            val_y !== 4'd3 || val_direcao !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_emit: en %0b tipo %0d x %0d y %0d dir %0b expected 1,0,2,3,0",
                     val_enable, val_tipo, val_x, val_y, val_direcao);
        end
        tick();
        n_tests++;
        if (val_enable !== 1'b0 || dut.estado_q !== AGUARDA) begin
            n_fail++;
            $display("FAIL basic_one_pulse: en %0b state %0d expected 0,AGUARDA",
                     val_enable, dut.estado_q);
        end
        respond(1'b1, 1'b0);
        tick();
        n_tests++;
        if (indice !== 4'd1 || dut.estado_q !== ESPERA) begin
            n_fail++;
            $display("FAIL basic_advance: idx %0d state %0d expected 1,ESPERA",
                     indice, dut.estado_q);
        end
    endtask

    task automatic test_conflict();
        place_ok(4'd0, 4'd0);
        place_ok(4'd0, 4'd1);
        pulse_confirma(4'd1, 4'd1, 1'b1, 3'd3);
        n_tests++;
        if (val_tipo !== 3'd2 || indice !== 4'd3) begin
            n_fail++;
            $display("FAIL conf_tipo: tipo %0d idx %0d expected 2,3", val_tipo, indice);
        end
        tick();
        respond(1'b0, 1'b1);
        n_tests++;
        if (erro !== 1'b1 || indice !== 4'd3 || dut.estado_q !== ERRO) begin
            n_fail++;
            $display("FAIL conf_erro: erro %0b idx %0d state %0d expected 1,3,ERRO",
                     erro, indice, dut.estado_q);
        end
        pulse_start();
        respond(1'b1, 1'b0);
        n_tests++;
        if (dut.estado_q !== ERRO || indice !== 4'd3) begin
            n_fail++;
            $display("FAIL erro_ignores: state %0d idx %0d expected ERRO,3",
                     dut.estado_q, indice);
        end
        pulse_confirma(4'd5, 4'd7, 1'b0, 3'd2);
        n_tests++;
        if (val_enable !== 1'b1 || val_x !== 4'd5 || val_y !== 4'd7 ||
            val_orientacao !== 3'd2 || erro !== 1'b0 || indice !== 4'd3) begin
            n_fail++;
            $display("FAIL retry_emit: en %0b x %0d y %0d ori %0d erro %0b idx %0d expected 1,5,7,2,0,3",
                     val_enable, val_x, val_y, val_orientacao, erro, indice);
        end
        tick();
        pulse_confirma(4'd9, 4'd9, 1'b1, 3'd7);
        n_tests++;
        if (dut.estado_q !== AGUARDA || val_x !== 4'd5 || val_y !== 4'd7 ||
            val_direcao !== 1'b0) begin
            n_fail++;
            $display("FAIL latch_stable: state %0d x %0d y %0d dir %0b expected AGUARDA,5,7,0",
                     dut.estado_q, val_x, val_y, val_direcao);
        end
        respond(1'b1, 1'b1);
        n_tests++;
        if (dut.estado_q !== ERRO || erro !== 1'b1 || indice !== 4'd3) begin
            n_fail++;
            $display("FAIL simultaneous: state %0d erro %0b idx %0d expected ERRO,1,3",
                     dut.estado_q, erro, indice);
        end
        pulse_confirma(4'd6, 4'd6, 1'b0, 3'd0);
        tick();
        respond(1'b1, 1'b0);
        tick();
        n_tests++;
        if (indice !== 4'd4 || dut.estado_q !== ESPERA) begin
            n_fail++;
            $display("FAIL retry_advance: idx %0d state %0d expected 4,ESPERA",
                     indice, dut.estado_q);
        end
    endtask

    task automatic test_wait();
        pulse_confirma(4'd8, 4'd2, 1'b1, 3'd0);
        tick();
`ifdef CONTROLE_TIMEOUT_EN
        for (int i = 0; i < 1022; i++) tick();
        n_tests++;
        if (dut.estado_q !== AGUARDA || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: state %0d erro %0b expected AGUARDA,0",
                     dut.estado_q, erro);
        end
        tick();
        n_tests++;
        if (dut.estado_q !== ERRO || erro !== 1'b1 || indice !== 4'd4) begin
            n_fail++;
            $display("FAIL timeout_fire: state %0d erro %0b idx %0d expected ERRO,1,4",
                     dut.estado_q, erro, indice);
        end
        pulse_confirma(4'd8, 4'd2, 1'b1, 3'd0);
        tick();
`else
        for (int i = 0; i < 1100; i++) tick();
        n_tests++;
        if (dut.estado_q !== AGUARDA || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout: state %0d erro %0b expected AGUARDA,0",
                     dut.estado_q, erro);
        end
`endif
        respond(1'b1, 1'b0);
        tick();
        n_tests++;
        if (indice !== 4'd5 || dut.estado_q !== ESPERA) begin
            n_fail++;
            $display("FAIL wait_advance: idx %0d state %0d expected 5,ESPERA",
                     indice, dut.estado_q);
        end
    endtask

    task automatic test_rollover();
        int tipo_errs;
        tipo_errs = 0;
        do_reset();
        pulse_start();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 11; i++) begin
                pulse_confirma(4'(i), 4'(10 - i), 1'(i % 2), 3'(i % 8));
                n_tests++;
                if (val_enable !== 1'b1 || val_tipo !== exp_tipo[i] || val_x !== 4'(i)) begin
                    n_fail++;
                    $display("FAIL fleet_tipo p%0d i%0d: en %0b tipo %0d x %0d expected 1,%0d,%0d",
                             p, i, val_enable, val_tipo, val_x, exp_tipo[i], i);
                end
                tick();
                respond(1'b1, 1'b0);
                tick();
            end
            if (p == 0) begin
                n_tests++;
                if (jogador !== 1'b1 || indice !== 4'd0 || concluido !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rollover: jog %0b idx %0d conc %0b expected 1,0,0",
                             jogador, indice, concluido);
                end
            end
        end
        n_tests++;
        if (concluido !== 1'b1 || dut.estado_q !== FIM || jogador !== 1'b1 ||
            indice !== 4'd10) begin
            n_fail++;
            $display("FAIL done: conc %0b state %0d jog %0b idx %0d expected 1,FIM,1,10",
                     concluido, dut.estado_q, jogador, indice);
        end
        pulse_confirma(4'd1, 4'd1, 1'b0, 3'd0);
        n_tests++;
        if (concluido !== 1'b1 || val_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL fim_ignores: conc %0b en %0b expected 1,0", concluido, val_enable);
        end
        pulse_start();
        n_tests++;
        if (dut.estado_q !== ESPERA || concluido !== 1'b0 || jogador !== 1'b0 ||
            indice !== 4'd0) begin
            n_fail++;
            $display("FAIL restart: state %0d conc %0b jog %0b idx %0d expected ESPERA,0,0,0",
                     dut.estado_q, concluido, jogador, indice);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        for (int i = 0; i < 17; i++) place_ok(4'd3, 4'(i % 11));
        n_tests++;
        if (jogador !== 1'b1 || indice !== 4'd6) begin
            n_fail++;
            $display("FAIL mid_setup: jog %0b idx %0d expected 1,6", jogador, indice);
        end
        pulse_confirma(4'd3, 4'd4, 1'b1, 3'd5);
        tick();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({val_enable, val_tipo, val_direcao, val_orientacao, val_x, val_y,
             jogador, indice, erro, concluido} !== 23'd0 || dut.estado_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid: outs %h state %0d expected 0,IDLE",
                     {val_enable, val_tipo, val_direcao, val_orientacao, val_x,
                      val_y, jogador, indice, erro, concluido}, dut.estado_q);
        end
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (dut.estado_q !== IDLE || indice !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_release: state %0d idx %0d expected IDLE,0",
                     dut.estado_q, indice);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_conflict();
        test_wait();
        test_rollover();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
